instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Sequences the 128-word instruction memory: owns the fetch PC, drives the memory address,
//  and buffers fetched words in a small FIFO toward decode. Fetch PC advances by 4; decode
//  pops through a valid/ready handshake. Branch/jump redirects flush the FIFO. Halt stops fetch.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch PC loaded on reset (low 2 bits must be 0)
//  DEPTH       2              FIFO entries (power of 2, >=2)
//  IMEM_WORDS  128            instruction memory size in words (bound check only)
// PORTS
//  Clk             in   1   clock, all state updates on rising edge
//  Reset           in   1   synchronous, active-high
//  ImemAddress     out  32  byte address to instruction memory (= FetchPC, combinational)
//  ImemInstr       in   32  word returned by memory, same cycle (combinational read)
//  RedirectValid   in   1   branch/jump taken this cycle
//  RedirectTarget  in   32  new fetch byte address; bits [1:0] forced to 0
//  Halt            in   1   level: suspend fetch while high
//  OutValid        out  1   FIFO head valid
//  OutReady        in   1   decode accepts head this cycle
//  OutInstr        out  32  head instruction word
//  OutPC           out  32  byte address of head instruction
//  Fault           out  1   sticky out-of-range fetch (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (sampled high at edge): FetchPC=RESET_PC, FIFO count=0, state=RUN; OutValid=0,
//    OutInstr=0, OutPC=0, Fault=0. Reset mid-operation discards all FIFO contents.
//  - States: RUN (fetch enabled), HALTED (no push), FAULT (no push, sticky until Reset).
//    RUN->HALTED when Halt=1; HALTED->RUN when Halt=0; RUN->FAULT on bound violation.
//  - Pop = OutValid & OutReady. Push allowed in RUN when count<DEPTH or pop same cycle.
//  - Push writes {FetchPC, ImemInstr} at tail; FetchPC <= FetchPC+4 (wraps 32'hFFFF_FFFC->0).
//  - Latency: first edge after Reset low pushes word at RESET_PC; OutValid=1 from that edge.
//    Steady state with OutReady=1: one instruction per cycle, no bubbles.
//  - Full (count==DEPTH, no pop): no push, FetchPC holds. Empty: OutValid=0, OutInstr/OutPC hold.
//  - Outputs are FIFO head registers; OutInstr/OutPC stable while OutValid=1 & OutReady=0.
//  - Redirect (priority over push/pop/Halt-transition of FIFO): count<=0, no push that cycle,
//    FetchPC <= {RedirectTarget[31:2],2'b00}; OutValid=0 next cycle; fetch from target on the
//    following edge. A pop in the redirect cycle is still a valid handoff to decode.
//  - Redirect while HALTED: updates FetchPC and flushes; stays HALTED. Ignored in FAULT.
//  - Halt does not flush: buffered entries still drain via handshake.
//  - count is $clog2(DEPTH)+1 bits; read/write pointers wrap modulo DEPTH.
// CONFIGURATION
//  IFU_BOUND_CHECK_EN defined: before push, if FetchPC[31:2] >= IMEM_WORDS, no push, state
//    -> FAULT, Fault=1 (sticky), FIFO drains normally; only Reset clears.
//  IFU_BOUND_CHECK_EN undefined: no check; FAULT state unreachable, Fault tied 0; memory
//    aliases address modulo IMEM_WORDS words.
// TESTING
//  1 Reset 2 cycles, OutReady=1, mem[0..2]=34090000,2012001d,2013000c -> OutPC 0,4,8 on
//    consecutive cycles with those words, OutValid continuous from first edge after Reset.
//  2 OutReady=0 for 5 cycles after reset -> count saturates at DEPTH, FetchPC=4*DEPTH,
//    OutInstr=34090000 stable; OutReady=1 -> words 0..DEPTH-1 then continue without gap.
//  3 At OutPC=8 assert RedirectValid, target 32'h0000002B -> next cycle OutValid=0, then
//    OutPC=32'h28 with mem[10]=15130001; stale entries for 0xC.. never appear.
//  4 Halt=1 with FIFO full, OutReady=1 -> DEPTH entries drain, then OutValid=0, FetchPC
//    frozen; Halt=0 -> fetch resumes at frozen FetchPC.
//  5 Reset asserted with FIFO full and redirect pending -> next cycle OutValid=0, Fault=0,
//    FetchPC=RESET_PC; first post-reset word is mem[0].
//  6 IFU_BOUND_CHECK_EN defined, redirect to 32'h200 -> no push, Fault=1 sticky, OutValid=0;
//    undefined -> word mem[0] fetched with OutPC=32'h200, Fault=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the fetch PC, drives the instruction memory
// address and buffers fetched words in a small FIFO toward decode.
// Optional build macro: IFU_BOUND_CHECK_EN (out-of-range fetch -> sticky fault).
//
// state    | meaning
// S_RUN    | fetch enabled, pushes whenever the FIFO has room
// S_HALTED | halt held high, no push; buffered entries still drain
// S_FAULT  | out-of-range fetch seen, no push, sticky until reset
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter int          IMEM_WORDS = 128
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [31:0] imem_address_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  input  logic        halt_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        fault_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_fetch_unit: DEPTH must be a power of 2 and >= 2");
  end
  if (RESET_PC[1:0] != 2'b00 || IMEM_WORDS < 1) begin : g_bad_cfg
    $error("instr_fetch_unit: RESET_PC must be word aligned and IMEM_WORDS >= 1");
  end

  typedef enum logic [1:0] {S_RUN, S_HALTED, S_FAULT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [31:0]     head_instr_q, head_instr_d;
  logic [31:0]     head_pc_q, head_pc_d;
  logic [31:0]     instr_buf [DEPTH];
  logic [31:0]     pc_buf [DEPTH];

  logic            redirect;
  logic            pop;
  logic            push;
  logic            fetch_ok;
  logic            oob;
  logic [CW-1:0]   remaining;
  logic [31:0]     target;

  assign imem_address_o = fetch_pc_q;
  assign out_valid_o    = (count_q != '0);
  assign out_instr_o    = head_instr_q;
  assign out_pc_o       = head_pc_q;
  assign target         = redirect_target_i & ~32'h3;

`ifdef IFU_BOUND_CHECK_EN
  assign oob     = ({2'b00, fetch_pc_q[31:2]} >= 32'(IMEM_WORDS));
  assign fault_o = (state_q == S_FAULT);
`else
  assign oob     = 1'b0;
  assign fault_o = 1'b0;
`endif

  always_comb begin
    redirect     = redirect_valid_i && (state_q != S_FAULT);
    pop          = out_valid_o && out_ready_i;
    fetch_ok     = (state_q == S_RUN) && !halt_i && !redirect;
    push         = fetch_ok && !oob && ((count_q < CW'(DEPTH)) || pop);
    remaining    = count_q - CW'(pop);

    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    count_d      = count_q + CW'(push) - CW'(pop);
    rptr_d       = rptr_q + PW'(pop);
    wptr_d       = wptr_q + PW'(push);
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;

    case (state_q)
      S_RUN: begin
        if (halt_i)              state_d = S_HALTED;
        else if (fetch_ok && oob) state_d = S_FAULT;
      end
      S_HALTED: if (!halt_i) state_d = S_RUN;
      default:  state_d = state_q;
    endcase

    if (redirect) begin
      // flush wins over everything; a pop this cycle has already been handed off
      fetch_pc_d = target;
      count_d    = '0;
      rptr_d     = '0;
      wptr_d     = '0;
    end else begin
      if (push) fetch_pc_d = fetch_pc_q + 32'd4;
      if (remaining != '0) begin
        head_instr_d = instr_buf[rptr_d];
        head_pc_d    = pc_buf[rptr_d];
      end else if (push) begin
        head_instr_d = imem_instr_i;
        head_pc_d    = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_RUN;
      fetch_pc_q   <= RESET_PC;
      count_q      <= '0;
      rptr_q       <= '0;
      wptr_q       <= '0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      count_q      <= count_d;
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
    end
  end

  // storage is only read while count says the slot is live, so no reset needed
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      instr_buf[wptr_q] <= imem_instr_i;
      pc_buf[wptr_q]    <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural 128-word memory
// and immediate-assertion checks at each step.
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] imem_address_o;
  logic [31:0] imem_instr_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic        halt_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;
  logic        fault_o;

  logic [31:0] mem [128];
  int tests = 0;
  int fails = 0;

  instr_fetch_unit dut (
    .clk_i(clk_i), .reset_i(reset_i), .imem_address_o(imem_address_o),
    .imem_instr_i(imem_instr_i), .redirect_valid_i(redirect_valid_i),
    .redirect_target_i(redirect_target_i), .halt_i(halt_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_instr_o(out_instr_o), .out_pc_o(out_pc_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  // memory aliases modulo 128 words
  assign imem_instr_i = mem[imem_address_o[8:2]];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[0]  = 32'h3409_0000;
    mem[1]  = 32'h2012_001d;
    mem[2]  = 32'h2013_000c;
    mem[10] = 32'h1513_0001;

    reset_i = 1'b1; redirect_valid_i = 1'b0; redirect_target_i = 32'h0;
    halt_i = 1'b0; out_ready_i = 1'b1;
    step(); step();
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_pc", out_pc_o, 32'h0);
    chk("rst_instr", out_instr_o, 32'h0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    chk("rst_addr", imem_address_o, 32'h0);

    // streaming with no bubbles
    reset_i = 1'b0;
    step();
    chk("t1_valid0", 32'(out_valid_o), 32'd1);
    chk("t1_pc0", out_pc_o, 32'h0);
    chk("t1_in0", out_instr_o, 32'h3409_0000);
    step();
    chk("t1_valid1", 32'(out_valid_o), 32'd1);
    chk("t1_pc1", out_pc_o, 32'h4);
    chk("t1_in1", out_instr_o, 32'h2012_001d);
    step();
    chk("t1_pc2", out_pc_o, 32'h8);
    chk("t1_in2", out_instr_o, 32'h2013_000c);

    // redirect while head is 0x8, target low bits dropped
    redirect_valid_i = 1'b1; redirect_target_i = 32'h0000_002B;
    step();
    redirect_valid_i = 1'b0;
    chk("t3_valid_gap", 32'(out_valid_o), 32'd0);
    chk("t3_addr", imem_address_o, 32'h28);
    step();
    chk("t3_valid", 32'(out_valid_o), 32'd1);
    chk("t3_pc", out_pc_o, 32'h28);
    chk("t3_in", out_instr_o, 32'h1513_0001);
    step();
    chk("t3_pc_next", out_pc_o, 32'h2C);
    chk("t3_in_next", out_instr_o, mem[11]);

    // backpressure saturates the FIFO
    reset_i = 1'b1; step();
    reset_i = 1'b0; out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_pc", out_pc_o, 32'h0);
      chk("t2_hold_in", out_instr_o, 32'h3409_0000);
    end
    chk("t2_fetchpc", imem_address_o, 32'h8);
    out_ready_i = 1'b1;
    step();
    chk("t2_pc1", out_pc_o, 32'h4);
    step();
    chk("t2_pc2", out_pc_o, 32'h8);
    step();
    chk("t2_pc3", out_pc_o, 32'hC);
    chk("t2_valid3", 32'(out_valid_o), 32'd1);

    // halt drains a full FIFO without further fetch
    out_ready_i = 1'b0;
    step(); step();
    chk("t4_full_addr", imem_address_o, 32'h14);
    halt_i = 1'b1; out_ready_i = 1'b1;
    step();
    chk("t4_drain_valid", 32'(out_valid_o), 32'd1);
    chk("t4_drain_pc", out_pc_o, 32'h10);
    step();
    chk("t4_empty", 32'(out_valid_o), 32'd0);
    chk("t4_frozen", imem_address_o, 32'h14);
    step();
    chk("t4_still_empty", 32'(out_valid_o), 32'd0);
    chk("t4_still_frozen", imem_address_o, 32'h14);
    halt_i = 1'b0;
    cyc = 0;
    while (!out_valid_o && cyc < 6) begin step(); cyc++; end
    chk("t4_resume_timeout", 32'(out_valid_o), 32'd1);
    chk("t4_resume_pc", out_pc_o, 32'h14);
    chk("t4_resume_in", out_instr_o, mem[5]);

    // reset with full FIFO and a redirect pending
    out_ready_i = 1'b0;
    step(); step();
    reset_i = 1'b1; redirect_valid_i = 1'b1; redirect_target_i = 32'h40;
    step();
    reset_i = 1'b0; redirect_valid_i = 1'b0;
    chk("t5_valid", 32'(out_valid_o), 32'd0);
    chk("t5_fault", 32'(fault_o), 32'd0);
    chk("t5_addr", imem_address_o, 32'h0);
    out_ready_i = 1'b1;
    step();
    chk("t5_pc", out_pc_o, 32'h0);
    chk("t5_in", out_instr_o, 32'h3409_0000);

    // redirect past the end of memory
    redirect_valid_i = 1'b1; redirect_target_i = 32'h200;
    step();
    redirect_valid_i = 1'b0;
    chk("t6_gap", 32'(out_valid_o), 32'd0);
    step();
`ifdef IFU_BOUND_CHECK_EN
    chk("t6_novalid", 32'(out_valid_o), 32'd0);
    chk("t6_fault", 32'(fault_o), 32'd1);
    redirect_valid_i = 1'b1; redirect_target_i = 32'h0;
    step();
    redirect_valid_i = 1'b0;
    step();
    chk("t6_sticky", 32'(fault_o), 32'd1);
    chk("t6_ignored_redirect", imem_address_o, 32'h200);
    chk("t6_still_novalid", 32'(out_valid_o), 32'd0);
`else
    chk("t6_valid", 32'(out_valid_o), 32'd1);
    chk("t6_pc", out_pc_o, 32'h200);
    chk("t6_in", out_instr_o, 32'h3409_0000);
    chk("t6_fault", 32'(fault_o), 32'd0);
    // fetch PC wraps from the top of the address space
    redirect_valid_i = 1'b1; redirect_target_i = 32'hFFFF_FFFC;
    step();
    redirect_valid_i = 1'b0;
    step();
    chk("wrap_pc", out_pc_o, 32'hFFFF_FFFC);
    chk("wrap_in", out_instr_o, mem[127]);
    step();
    chk("wrap_pc0", out_pc_o, 32'h0);
    chk("wrap_in0", out_instr_o, 32'h3409_0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
